// File: rtl/bcd_pkg.sv
// Shared BCD digit types, limits and helpers for the key-stepped BCD counter.
package bcd_pkg;

   localparam int unsigned BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef logic [BCD_W-1:0] bcd_t;

   // Action taken by the counter in a given cycle; load outranks step.
   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_STEP,
      ACT_LOAD
   } act_e;

   function automatic bcd_t bcd_clamp(input logic [BCD_W-1:0] v);
      return (v > BCD_MAX) ? BCD_MAX : bcd_t'(v);
   endfunction

endpackage

// File: rtl/key_bcd_counter_if.sv
// Switch/button inputs and BCD digit/event outputs of the key-stepped counter.
interface key_bcd_counter_if;
   import bcd_pkg::*;

   logic key_n;
   logic load_n;
   logic up;
   logic [BCD_W-1:0] load_tens;
   logic [BCD_W-1:0] load_ones;
   bcd_t tens;
   bcd_t ones;
   logic step_evt;
   logic wrap;

   modport master (
      output key_n, load_n, up, load_tens, load_ones,
      input  tens, ones, step_evt, wrap
   );

   modport slave (
      input  key_n, load_n, up, load_tens, load_ones,
      output tens, ones, step_evt, wrap
   );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer, hold-time debounce and press (1->0) detect for one
// active-low pushbutton.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic raw_n,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= raw_n;
         r_sync2 <= r_sync1;
      end
   end

   // The new level is accepted only after it has differed for a full window.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_stable   <= 1'b1;
         r_stable_d <= 1'b1;
         r_cnt      <= '0;
      end else begin
         r_stable_d <= r_stable;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign press = r_stable_d & ~r_stable;

endmodule

// File: rtl/key_bcd_counter.sv
// Two-digit BCD up/down counter stepped by a debounced key and loadable from
// switches; digits are always 0-9 for the downstream 7-segment decoders.
module key_bcd_counter
   import bcd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input logic              CLOCK_50,
   input logic              reset,
   key_bcd_counter_if.slave bus
);

   logic w_step_press;
   logic w_load_press;
   act_e w_act;

   bcd_t r_tens;
   bcd_t r_ones;
   logic r_step_evt;
   logic r_wrap;

   bcd_t w_tens_nxt;
   bcd_t w_ones_nxt;
   logic w_step_nxt;
   logic w_wrap_nxt;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .raw_n    (bus.key_n),
      .press    (w_step_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .raw_n    (bus.load_n),
      .press    (w_load_press)
   );

   always_comb begin
      w_act = ACT_NONE;
      if (w_load_press) begin
         w_act = ACT_LOAD;
      end else if (w_step_press) begin
         w_act = ACT_STEP;
      end
   end

   always_comb begin
      w_tens_nxt = r_tens;
      w_ones_nxt = r_ones;
      w_step_nxt = 1'b0;
      w_wrap_nxt = 1'b0;
      case (w_act)
         ACT_LOAD: begin
            w_tens_nxt = bcd_clamp(bus.load_tens);
            w_ones_nxt = bcd_clamp(bus.load_ones);
         end
         ACT_STEP: begin
            w_step_nxt = 1'b1;
            if (bus.up) begin
               if (r_ones == BCD_MAX) begin
                  w_ones_nxt = '0;
                  if (r_tens == BCD_MAX) begin
                     w_tens_nxt = '0;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_tens_nxt = r_tens + 4'd1;
                  end
               end else begin
                  w_ones_nxt = r_ones + 4'd1;
               end
            end else begin
               if (r_ones == '0) begin
                  w_ones_nxt = BCD_MAX;
                  if (r_tens == '0) begin
                     w_tens_nxt = BCD_MAX;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_tens_nxt = r_tens - 4'd1;
                  end
               end else begin
                  w_ones_nxt = r_ones - 4'd1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_tens     <= '0;
         r_ones     <= '0;
         r_step_evt <= 1'b0;
         r_wrap     <= 1'b0;
      end else begin
         r_tens     <= w_tens_nxt;
         r_ones     <= w_ones_nxt;
         r_step_evt <= w_step_nxt;
         r_wrap     <= w_wrap_nxt;
      end
   end

   assign bus.tens     = r_tens;
   assign bus.ones     = r_ones;
   assign bus.step_evt = r_step_evt;
   assign bus.wrap     = r_wrap;

endmodule

// File: tb/tb_key_bcd_counter.sv
// Directed bench for key_bcd_counter with a 4-cycle debounce window; inputs
// change and outputs are sampled on the falling clock edge.
module tb_key_bcd_counter;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   key_bcd_counter_if bus ();

   key_bcd_counter #(.DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_digits(input string tag, input logic [3:0] t, input logic [3:0] o);
      chk({tag, "_tens"}, 8'(bus.tens), 8'(t));
      chk({tag, "_ones"}, 8'(bus.ones), 8'(o));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
   endtask

   // Fall to visible step_evt is 2 sync + 4 debounce + 1 register = 7 cycles.
   task automatic press_key(input string tag, input logic dir,
                            input logic [3:0] et, input logic [3:0] eo, input logic ew);
      bus.up    = dir;
      bus.key_n = 1'b0;
      cyc(6);
      chk({tag, "_pre_evt"}, 8'(bus.step_evt), 8'd0);
      cyc(1);
      chk({tag, "_evt"}, 8'(bus.step_evt), 8'd1);
      chk({tag, "_wrap"}, 8'(bus.wrap), 8'(ew));
      chk_digits(tag, et, eo);
      cyc(1);
      chk({tag, "_evt_end"}, 8'(bus.step_evt), 8'd0);
      chk({tag, "_wrap_end"}, 8'(bus.wrap), 8'd0);
      bus.key_n = 1'b1;
      cyc(8);
   endtask

   task automatic press_load(input string tag, input logic [3:0] lt, input logic [3:0] lo,
                             input logic [3:0] et, input logic [3:0] eo);
      bus.load_tens = lt;
      bus.load_ones = lo;
      bus.load_n    = 1'b0;
      cyc(7);
      chk_digits(tag, et, eo);
      chk({tag, "_evt"}, 8'(bus.step_evt), 8'd0);
      chk({tag, "_wrap"}, 8'(bus.wrap), 8'd0);
      bus.load_n = 1'b1;
      cyc(8);
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      reset         = 1'b1;
      bus.key_n     = 1'b1;
      bus.load_n    = 1'b1;
      bus.up        = 1'b1;
      bus.load_tens = 4'd0;
      bus.load_ones = 4'd0;

      // Reset state
      cyc(3);
      chk_digits("rst", 4'd0, 4'd0);
      chk("rst_evt", 8'(bus.step_evt), 8'd0);
      chk("rst_wrap", 8'(bus.wrap), 8'd0);
      reset = 1'b0;
      cyc(3);
      chk("post_rst_evt", 8'(bus.step_evt), 8'd0);

      // Held key: one event exactly 7 cycles after the fall, none after
      bus.up    = 1'b1;
      bus.key_n = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         chk($sformatf("hold_evt_c%0d", k), 8'(bus.step_evt), (k == 7) ? 8'd1 : 8'd0);
      end
      chk_digits("hold", 4'd0, 4'd1);
      chk("hold_wrap", 8'(bus.wrap), 8'd0);
      bus.key_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         chk($sformatf("release_evt_c%0d", k), 8'(bus.step_evt), 8'd0);
      end

      // 2-cycle glitch is ignored
      do_reset();
      cyc(2);
      bus.key_n = 1'b0;
      cyc(2);
      bus.key_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         chk($sformatf("glitch_evt_c%0d", k), 8'(bus.step_evt), 8'd0);
      end
      chk_digits("glitch", 4'd0, 4'd0);

      // Carry into tens and 99 -> 00 wrap
      press_load("ld09", 4'd0, 4'd9, 4'd0, 4'd9);
      press_key("up09", 1'b1, 4'd1, 4'd0, 1'b0);
      press_load("ld99", 4'd9, 4'd9, 4'd9, 4'd9);
      press_key("up99", 1'b1, 4'd0, 4'd0, 1'b1);

      // 00 -> 99 wrap, then borrow-free decrement
      do_reset();
      cyc(2);
      chk_digits("rst2", 4'd0, 4'd0);
      press_key("dn00", 1'b0, 4'd9, 4'd9, 1'b1);
      press_key("dn99", 1'b0, 4'd9, 4'd8, 1'b0);

      // Clamp of out-of-range switch values
      press_load("ldCF", 4'hC, 4'hF, 4'd9, 4'd9);

      // Simultaneous load and step: load wins, no step_evt
      bus.up        = 1'b1;
      bus.load_tens = 4'd3;
      bus.load_ones = 4'd7;
      bus.key_n     = 1'b0;
      bus.load_n    = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         chk($sformatf("both_evt_c%0d", k), 8'(bus.step_evt), 8'd0);
      end
      chk_digits("both", 4'd3, 4'd7);
      chk("both_wrap", 8'(bus.wrap), 8'd0);
      bus.key_n  = 1'b1;
      bus.load_n = 1'b1;
      cyc(8);

      // Reset in the middle of a debounce count restarts the window
      bus.up    = 1'b1;
      bus.key_n = 1'b0;
      cyc(4);
      chk_digits("mid_pre", 4'd3, 4'd7);
      reset = 1'b1;
      cyc(1);
      chk_digits("mid_rst", 4'd0, 4'd0);
      chk("mid_rst_evt", 8'(bus.step_evt), 8'd0);
      reset = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         cyc(1);
         chk($sformatf("mid_evt_c%0d", k), 8'(bus.step_evt), (k == 7) ? 8'd1 : 8'd0);
      end
      chk_digits("mid_after", 4'd0, 4'd1);
      bus.key_n = 1'b1;
      cyc(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
